// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 types, constants and FSM states for the FP datapath
package fp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  localparam int FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  typedef struct packed {
    logic sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: classify a binary32 operand, flush denormals, prepend the hidden bit
module fp_unpack (
  input  logic [31:0] x,
  input  logic        neg,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] man,
  output logic        is_inf,
  output logic        is_nan
);
  import fp_pkg::*;
  fp32_t f;
  logic is_zero;
  assign f = x;
  assign is_zero = f.exp == 8'd0;
  assign sign = f.sign ^ neg;
  assign exp = f.exp;
  assign man = is_zero ? 24'd0 : {1'b1, f.frac};
  assign is_inf = f.exp == FP_EXP_MAX && f.frac == 23'd0;
  assign is_nan = f.exp == FP_EXP_MAX && f.frac != 23'd0;
endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle binary32 subtractor (align / add / normalize) behind valid/ready
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);
  import fp_pkg::*;
  state_t state, state_d;
  logic sa, sb, sr, sub, sa_d, sb_d, sr_d, sub_d;
  logic [7:0] ea, eb, ea_d, eb_d, diff;
  logic [23:0] ma, mb, ma_d, mb_d, small_m;
  logic [24:0] sum;
  logic [31:0] res_d, spec_res;
  logic ovf_d, unf_d, a_big, spec_nan;
  logic ua_s, ub_s, ua_inf, ub_inf, ua_nan, ub_nan;
  logic [7:0] ua_e, ub_e;
  logic [23:0] ua_m, ub_m;

  fp_unpack u_unpack_a (.x(a), .neg(1'b0), .sign(ua_s), .exp(ua_e), .man(ua_m), .is_inf(ua_inf), .is_nan(ua_nan));
  fp_unpack u_unpack_b (.x(b), .neg(1'b1), .sign(ub_s), .exp(ub_e), .man(ub_m), .is_inf(ub_inf), .is_nan(ub_nan));

  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign spec_nan = ua_nan | ub_nan | (ua_inf & ub_inf & (ua_s != ub_s));
  assign spec_res = spec_nan ? FP_QNAN : FP_POS_INF | {ua_inf ? ua_s : ub_s, 31'd0};
  assign a_big = {ea, ma} >= {eb, mb};
  assign diff = a_big ? ea - eb : eb - ea;
  assign small_m = a_big ? mb : ma;
  assign sum = sub ? {1'b0, ma} - {1'b0, mb} : {1'b0, ma} + {1'b0, mb};

  // Next-state and datapath updates; b arrives already negated so the core only adds
  always_comb begin
    state_d = state;
    sa_d = sa;
    sb_d = sb;
    sr_d = sr;
    sub_d = sub;
    ea_d = ea;
    eb_d = eb;
    ma_d = ma;
    mb_d = mb;
    res_d = result;
    ovf_d = overflow;
    unf_d = underflow;
    case (state)
      S_IDLE: if (in_valid) begin
        sa_d = ua_s;
        sb_d = ub_s;
        ea_d = ua_e;
        eb_d = ub_e;
        ma_d = ua_m;
        mb_d = ub_m;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (ua_e == FP_EXP_MAX || ub_e == FP_EXP_MAX) begin
          res_d = spec_res;
          state_d = S_DONE;
        end else state_d = S_ALIGN;
      end
      S_ALIGN: begin
        sr_d = a_big ? sa : sb;
        sub_d = sa ^ sb;
        ea_d = a_big ? ea : eb;
        ma_d = a_big ? ma : mb;
        mb_d = diff >= 8'd25 ? 24'd0 : small_m >> diff;
        state_d = S_ADD;
      end
      S_ADD: if (sum[24]) begin
        ma_d = sum[24:1];
        ea_d = ea + 8'd1;
        if (ea == 8'd254) begin
          res_d = FP_POS_INF | {sr, 31'd0};
          ovf_d = 1'b1;
          state_d = S_DONE;
        end else state_d = S_NORM;
      end else if (sum == 25'd0) begin
        res_d = 32'd0;
        state_d = S_DONE;
      end else begin
        ma_d = sum[23:0];
        state_d = S_NORM;
      end
      S_NORM: if (ma[23]) begin
        res_d = {sr, ea, ma[22:0]};
        state_d = S_DONE;
      end else if (ea > 8'd1) begin
        ma_d = ma << 1;
        ea_d = ea - 8'd1;
      end else begin
        res_d = {sr, 31'd0};
        unf_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_d;
  end

  // Operand, working and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa <= 1'b0;
      sb <= 1'b0;
      sr <= 1'b0;
      sub <= 1'b0;
      ea <= 8'd0;
      eb <= 8'd0;
      ma <= 24'd0;
      mb <= 24'd0;
      result <= 32'd0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sa <= sa_d;
      sb <= sb_d;
      sr <= sr_d;
      sub <= sub_d;
      ea <= ea_d;
      eb <= eb_d;
      ma <= ma_d;
      mb <= mb_d;
      result <= res_d;
      overflow <= ovf_d;
      underflow <= unf_d;
    end
  end
endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: directed checks of fp_sub_seq results, latency, handshake and reset
module tb_fp_sub_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic in_ready, out_valid, overflow, underflow;
  logic [31:0] result;
  int total = 0;
  int bad = 0;

  fp_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic eo, input logic eu, input int el);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = $urandom;
    b = $urandom;
    wait_valid(lat);
    in_valid = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(el));
    chk({tag, ".result"}, result, er);
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".underflow"}, 32'(underflow), 32'(eu));
    chk({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".back_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("3m1", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4);
    do_op("1m075", 32'h3F800000, 32'h3F400000, 32'h3E800000, 1'b0, 1'b0, 6);
    do_op("1mneg1", 32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 4);
    do_op("xmx", 32'h41200000, 32'h41200000, 32'h00000000, 1'b0, 1'b0, 3);
    do_op("ovf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 3);
    do_op("infminf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0, 1);
    do_op("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1);
    do_op("1minf", 32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 1);
    do_op("unf", 32'h00C00000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 4);
    do_op("ovf_then_clean", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4);

    @(negedge clk);
    a = 32'h40400000;
    b = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp.valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp.result", result, 32'h40000000);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp.release", 32'(in_ready), 32'd1);

    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h3F400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.result", result, 32'd0);
    chk("midrst.overflow", 32'(overflow), 32'd0);
    chk("midrst.underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("midrst.no_valid", 32'(seen), 32'd0);
    chk("midrst.idle", 32'(in_ready), 32'd1);

    do_op("after_rst", 32'h3F800000, 32'h3F400000, 32'h3E800000, 1'b0, 1'b0, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
